// File: rtl/fc_argmax_pkg.sv
`default_nettype none
// ============================================================================
// fc_argmax_pkg : shared types, default sizes and lane-index helper
// Revision      : 1.0
// ============================================================================
package fc_argmax_pkg;

  localparam int DEF_DATA_SIZE      = 8;
  localparam int DEF_H_CIM_TILES    = 2;
  localparam int DEF_NUM_CHANNELS   = 2;
  localparam int DEF_NUM_BEATS      = 8;
  localparam int DEF_OUTPUT_NEURONS = 10;

  localparam int LANES = DEF_H_CIM_TILES * DEF_NUM_CHANNELS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int lane_idx(input int h, input int b, input int c,
                                  input int num_beats, input int num_channels);
    return (h * num_beats + b) * num_channels + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_lane_tree.sv
`default_nettype none
// ============================================================================
// argmax_lane_tree : max/index over one beat of masked lanes, lowest index wins
// Revision         : 1.0
// ============================================================================
module argmax_lane_tree
  import fc_argmax_pkg::*;
#(
  parameter int N_LANES      = LANES,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int GROUP        = DEF_NUM_CHANNELS,
  parameter int GROUP_STRIDE = DEF_NUM_BEATS * DEF_NUM_CHANNELS,
  parameter int IDX_W        = 5
) (
  input  logic [N_LANES-1:0][DATA_SIZE-1:0] vals_i,
  input  logic [N_LANES-1:0]                valid_i,
  input  logic [IDX_W-1:0]                  base_i,
  output logic [DATA_SIZE-1:0]              max_o,
  output logic [IDX_W-1:0]                  idx_o,
  output logic                              any_valid_o
);

  logic [DATA_SIZE-1:0] best_val;
  logic [IDX_W-1:0]     best_idx;
  logic                 best_any;

  // Lane order h*GROUP+c is monotonic in neuron index, so a strict '>' scan
  // from lane 0 upward keeps the lowest index on ties.
  always_comb begin
    best_val = '0;
    best_idx = '0;
    best_any = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      if (valid_i[l] && (!best_any || (vals_i[l] > best_val))) begin
        best_val = vals_i[l];
        best_idx = base_i + IDX_W'((l / GROUP) * GROUP_STRIDE + (l % GROUP));
        best_any = 1'b1;
      end
    end
  end

  assign max_o       = best_val;
  assign idx_o       = best_idx;
  assign any_valid_o = best_any;

endmodule
`default_nettype wire

// File: rtl/fc_argmax_sink.sv
`default_nettype none
// ============================================================================
// fc_argmax_sink : pipelined argmax over FC-layer output beats, valid/ack result
// Revision       : 1.0
// ============================================================================
module fc_argmax_sink
  import fc_argmax_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int H_CIM_TILES    = DEF_H_CIM_TILES,
  parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int NUM_BEATS      = DEF_NUM_BEATS,
  parameter int OUTPUT_NEURONS = DEF_OUTPUT_NEURONS,
  parameter int CLASS_WIDTH    = $clog2(H_CIM_TILES * NUM_BEATS * NUM_CHANNELS)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 i_start,
  output logic                                                 o_ready,
  input  logic                                                 i_we,
  input  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  output logic                                                 o_valid,
  output logic [CLASS_WIDTH-1:0]                               o_class,
  output logic [DATA_SIZE-1:0]                                 o_max,
  input  logic                                                 i_ack
);

  localparam int N_LANES = H_CIM_TILES * NUM_CHANNELS;
  localparam int BEAT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_e                 state_q,   state_d;
  logic [BEAT_W-1:0]      beat_q,    beat_d;
  logic                   s1_occ_q,  s1_occ_d;
  logic                   s1_vld_q,  s1_vld_d;
  logic [DATA_SIZE-1:0]   s1_max_q,  s1_max_d;
  logic [CLASS_WIDTH-1:0] s1_idx_q,  s1_idx_d;
  logic                   s2_occ_q,  s2_occ_d;
  logic [DATA_SIZE-1:0]   run_max_q, run_max_d;
  logic [CLASS_WIDTH-1:0] run_cls_q, run_cls_d;
  logic                   seen_q,    seen_d;

  logic [N_LANES-1:0]     lane_vld;
  logic [CLASS_WIDTH-1:0] beat_base;
  logic [DATA_SIZE-1:0]   tree_max;
  logic [CLASS_WIDTH-1:0] tree_idx;
  logic                   tree_any;
  logic                   accept;

  always_comb begin
    lane_vld = '0;
    for (int h = 0; h < H_CIM_TILES; h++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        lane_vld[h*NUM_CHANNELS+c] =
          lane_idx(h, int'(beat_q), c, NUM_BEATS, NUM_CHANNELS) < OUTPUT_NEURONS;
      end
    end
  end

  assign beat_base = CLASS_WIDTH'(int'(beat_q) * NUM_CHANNELS);

  argmax_lane_tree #(
    .N_LANES      (N_LANES),
    .DATA_SIZE    (DATA_SIZE),
    .GROUP        (NUM_CHANNELS),
    .GROUP_STRIDE (NUM_BEATS * NUM_CHANNELS),
    .IDX_W        (CLASS_WIDTH)
  ) u_tree (
    .vals_i      (i_data),
    .valid_i     (lane_vld),
    .base_i      (beat_base),
    .max_o       (tree_max),
    .idx_o       (tree_idx),
    .any_valid_o (tree_any)
  );

  assign accept = (state_q == ARMED) && i_we;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    s1_occ_d  = accept;
    s1_vld_d  = accept && tree_any;
    s1_max_d  = s1_max_q;
    s1_idx_d  = s1_idx_q;
    s2_occ_d  = s1_occ_q;
    run_max_d = run_max_q;
    run_cls_d = run_cls_q;
    seen_d    = seen_q;

    if (accept) begin
      s1_max_d = tree_max;
      s1_idx_d = tree_idx;
    end

    // First candidate of an inference is taken unconditionally so an
    // all-zero result still reports neuron 0.
    if (s1_vld_q && (!seen_q || (s1_max_q > run_max_q))) begin
      run_max_d = s1_max_q;
      run_cls_d = s1_idx_q;
      seen_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = ARMED;
          beat_d    = '0;
          run_max_d = '0;
          run_cls_d = '0;
          seen_d    = 1'b0;
        end
      end
      ARMED: begin
        if (i_we) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN;
            beat_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (!s1_occ_q && !s2_occ_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      s1_occ_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_max_q  <= '0;
      s1_idx_q  <= '0;
      s2_occ_q  <= 1'b0;
      run_max_q <= '0;
      run_cls_q <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      s1_occ_q  <= s1_occ_d;
      s1_vld_q  <= s1_vld_d;
      s1_max_q  <= s1_max_d;
      s1_idx_q  <= s1_idx_d;
      s2_occ_q  <= s2_occ_d;
      run_max_q <= run_max_d;
      run_cls_q <= run_cls_d;
      seen_q    <= seen_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_class = run_cls_q;
  assign o_max   = run_max_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_sink.sv
`default_nettype none
// ============================================================================
// tb_fc_argmax_sink : randomized + directed bench with neuron-level argmax model
// Revision          : 1.0
// ============================================================================
module tb_fc_argmax_sink;

  localparam int DW = 8;
  localparam int HT = 2;
  localparam int NC = 2;
  localparam int NB = 8;
  localparam int ON = 10;
  localparam int CW = 5;
  localparam int NL = HT * NB * NC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic i_we = 1'b0;
  logic i_ack = 1'b0;
  logic [HT-1:0][NC-1:0][DW-1:0] i_data = '0;
  logic          o_ready;
  logic          o_valid;
  logic [CW-1:0] o_class;
  logic [DW-1:0] o_max;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected handshake phase and result of the current inference
  bit m_ready = 1'b1;
  bit m_valid = 1'b0;
  bit chk_en  = 1'b0;
  int exp_class = 0;
  int exp_max   = 0;
  int nv[NL];

  fc_argmax_sink #(
    .DATA_SIZE      (DW),
    .H_CIM_TILES    (HT),
    .NUM_CHANNELS   (NC),
    .NUM_BEATS      (NB),
    .OUTPUT_NEURONS (ON),
    .CLASS_WIDTH    (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .o_ready (o_ready),
    .i_we    (i_we),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_class (o_class),
    .o_max   (o_max),
    .i_ack   (i_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Argmax over the valid neuron list: first neuron seeds, strictly larger replaces
  function automatic void model(output int c, output int m);
    c = 0;
    m = nv[0];
    for (int i = 1; i < ON; i++) begin
      if (nv[i] > m) begin
        c = i;
        m = nv[i];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", int'(o_ready), int'(m_ready));
      check("valid", int'(o_valid), int'(m_valid));
      if (m_valid) begin
        check("class", int'(o_class), exp_class);
        check("max",   int'(o_max),   exp_max);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int b);
    for (int h = 0; h < HT; h++)
      for (int c = 0; c < NC; c++)
        i_data[h][c] = DW'(nv[(h * NB + b) * NC + c]);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NL; i++) nv[i] = v;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < NL; i++) nv[i] = int'($urandom_range(0, maxv));
  endtask

  task automatic run_inference(input int gap_max, input bit lit_en,
                               input int lit_c, input int lit_m);
    int g;
    model(exp_class, exp_max);
    if (lit_en) begin
      check("model_class", exp_class, lit_c);
      check("model_max",   exp_max,   lit_m);
    end
    // start together with a beat: the beat must be dropped
    i_start = 1'b1;
    i_we    = 1'b1;
    i_data  = '1;
    tick();
    i_start = 1'b0;
    i_we    = 1'b0;
    m_ready = 1'b0;
    for (int b = 0; b < NB; b++) begin
      g = int'($urandom_range(0, gap_max));
      repeat (g) begin
        i_we    = 1'b0;
        i_start = 1'($urandom_range(0, 1));
        i_data  = 32'($urandom);
        tick();
      end
      i_start = 1'($urandom_range(0, 1));
      i_we    = 1'b1;
      drive_beat(b);
      tick();
    end
    i_start = 1'b0;
    // stray beats while draining must not leak into the result
    i_we   = 1'b1;
    i_data = '1;
    tick();
    tick();
    i_we = 1'b0;
    tick();
    m_valid = 1'b1;
    if (lit_en) begin
      check("lit_class", int'(o_class), lit_c);
      check("lit_max",   int'(o_max),   lit_m);
    end
    repeat (int'($urandom_range(1, 3))) begin
      i_start = 1'($urandom_range(0, 1));
      i_we    = 1'($urandom_range(0, 1));
      i_data  = '1;
      tick();
    end
    i_start = 1'b0;
    i_we    = 1'b0;
    i_ack   = 1'b1;
    tick();
    i_ack   = 1'b0;
    m_valid = 1'b0;
    m_ready = 1'b1;
    i_we    = 1'b1;
    i_data  = '1;
    tick();
    i_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", int'(o_ready), 1);
    check("reset_valid", int'(o_valid), 0);
    check("reset_class", int'(o_class), 0);
    check("reset_max",   int'(o_max),   0);
    #2 rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // single maximum at neuron 7 (h=0, b=3, c=1)
    fill_const(5);
    nv[7] = 200;
    run_inference(0, 1'b1, 7, 200);

    // tie across beats resolves to the lower neuron
    fill_const(10);
    nv[2] = 90;
    nv[9] = 90;
    run_inference(4, 1'b1, 2, 90);

    // masked lanes never win, even at full scale
    fill_const(0);
    for (int i = ON; i < NL; i++) nv[i] = 255;
    nv[3] = 50;
    run_inference(2, 1'b1, 3, 50);

    // same data back-to-back and with gaps
    fill_random(255);
    run_inference(0, 1'b0, 0, 0);
    run_inference(4, 1'b0, 0, 0);

    // all zero still produces a result
    fill_const(0);
    run_inference(3, 1'b1, 0, 0);

    // reset after four beats aborts the inference
    fill_const(0);
    nv[1] = 250;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_we = 1'b1;
      drive_beat(b);
      tick();
    end
    i_we = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("abort_ready", int'(o_ready), 1);
    check("abort_valid", int'(o_valid), 0);
    check("abort_class", int'(o_class), 0);
    check("abort_max",   int'(o_max),   0);
    m_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    fill_const(20);
    nv[4] = 77;
    run_inference(1, 1'b1, 4, 77);

    // randomized inferences, small ranges force intra-beat ties
    for (int k = 0; k < 10; k++) begin
      fill_random(($urandom_range(0, 1) == 1) ? 255 : 3);
      run_inference(int'($urandom_range(0, 4)), 1'b0, 0, 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
